svm_multi_decision: RTL
=======================

Name: svm_multi_decision

Overview:
- Generalised SVM decision stage for N one-vs-rest classifiers. The original two-output valence/arousal stage is extended to N channels.
- Consumes the per-classifier second-matmul scores as a valid/ready stream, one score per classifier in channel order.
- Compares each score against its own intercept with overflow-safe signed arithmetic and assembles an N-bit decision vector per frame.
- Buffers decision vectors in a 2-entry output FIFO with a full valid/ready handshake, and flags framing errors.

Parameters:
- NBITS, 16, fixed-point word width of features/weights
- LOG_F_WIDTH, 7, log2 of feature count (accumulation growth of first matmul)
- LOG_SUP_WIDTH, 9, log2 of support-vector count (accumulation growth of second matmul)
- NUM_CLS, 2, number of classifiers (channels) per frame, >= 1
- LOG_NUM_CLS, 1, ceil(log2(NUM_CLS)), minimum 1
- INCLUSIVE, 0, 0: decision = (score + intercept) > 0; 1: decision = (score + intercept) >= 0
- Derived: RW = NBITS*(NBITS+LOG_F_WIDTH)+LOG_SUP_WIDTH; IW = 2*NBITS+LOG_SUP_WIDTH; SW = max(RW,IW)+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- result  in  RW  signed classifier score
- result_valid  in  1  score valid
- result_last  in  1  marks final score of a frame
- result_ready  out  1  block can accept score
- intercepts  in  NUM_CLS*IW  signed intercepts, channel c at bits [c*IW +: IW]; quasi-static
- dout_valid  out  1  decision vector available
- dout_ready  in  1  consumer accepts
- dout_fire  out  1  dout_valid && dout_ready
- dout_decision  out  NUM_CLS  bit c = decision of classifier c
- frame_err  out  1  sticky framing-error flag

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - result_ready=1, dout_valid=0, dout_decision=0, frame_err=0.
  - Channel counter chan_idx=0, partial vector=0, FIFO empty (count=0, pointers 0).
- Input accept: in_fire = result_valid && result_ready.
- result_ready = !(chan_idx == NUM_CLS-1 && fifo_count == 2).
  - Depends on registered state only; no combinational path from dout_ready.
  - Scores for non-final channels are always accepted.
- Arithmetic:
  - Sign-extend score and intercepts[chan_idx] to SW bits and add.
  - bit = INCLUSIVE ? (sum >= 0) : (sum > 0).
  - No negation of the intercept, so no overflow at the most-negative intercept.
- On in_fire at chan_idx = k < NUM_CLS-1:
  - Partial bit k <= bit; chan_idx <= k+1.
  - If result_last=1: the frame is discarded (no push), chan_idx <= 0, partial <= 0, frame_err <= 1.
- On in_fire at chan_idx = NUM_CLS-1:
  - Push {bit, partial[NUM_CLS-2:0]} into the FIFO; chan_idx <= 0; partial <= 0.
  - If result_last=0: the frame is still pushed and frame_err <= 1.
- NUM_CLS=1: every accepted score is a final channel.
- FIFO:
  - 2 entries; head drives dout_decision; dout_valid = (count != 0), registered.
  - Pop on dout_fire.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Push when count=2 is impossible, because result_ready is low.
- Latency: final-channel accept at edge t -> dout_valid=1 from cycle t+1 if the FIFO was empty.
  - Throughput: one vector per NUM_CLS accepted scores, no bubbles while dout_ready=1.
- dout_decision holds stable while dout_valid && !dout_ready.
- frame_err clears only on rst.
- Reset mid-frame: the partial frame and FIFO contents are dropped; nothing is emitted after reset until a full new frame arrives.

Test Plan (NBITS=4, LOG_F_WIDTH=2, LOG_SUP_WIDTH=3, NUM_CLS=3: RW=27, IW=11):
- Basic frame: intercepts {c0=-5, c1=10, c2=0}; scores 6, -10, 0 with last on the 3rd, INCLUSIVE=0 -> one cycle after the 3rd accept, dout_valid=1 and dout_decision=3'b001; frame_err=0.
- Inclusive mode: same stimulus with INCLUSIVE=1 -> dout_decision=3'b111.
- Overflow corner: intercept c0=-1024 (IW min), score 1025 -> bit0=1; score 1024 -> bit0=0 (INCLUSIVE=0).
- Backpressure: dout_ready=0, send 3 frames -> after 2 frames, result_ready drops only when chan_idx=2; 3rd final score is held; raising dout_ready pops frames in order and the 3rd frame is then accepted; no loss or duplication.
- Framing errors:
  - last asserted on channel 1 -> no output, frame_err=1, the next frame aligns at channel 0.
  - Missing last on channel 2 -> frame emitted, frame_err stays 1.
- Reset mid-frame: rst after 2 scores with 1 entry queued -> dout_valid=0 next cycle; the next clean frame emits exactly one correct vector.

Source files
------------

// File: rtl/svm_multi_decision.sv
// N-channel one-vs-rest SVM decision stage: scores stream in channel order, each is
// compared against its own intercept, and whole-frame decision vectors leave via a 2-entry FIFO.
module svm_multi_decision #(
    parameter int NBITS         = 16,
    parameter int LOG_F_WIDTH   = 7,
    parameter int LOG_SUP_WIDTH = 9,
    parameter int NUM_CLS       = 2,
    parameter int LOG_NUM_CLS   = 1,
    parameter int INCLUSIVE     = 0,
    localparam int RW = NBITS * (NBITS + LOG_F_WIDTH) + LOG_SUP_WIDTH,
    localparam int IW = 2 * NBITS + LOG_SUP_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [RW-1:0]      result,
    input  logic                      result_valid,
    input  logic                      result_last,
    output logic                      result_ready,
    input  logic [NUM_CLS*IW-1:0]     intercepts,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      dout_fire,
    output logic [NUM_CLS-1:0]        dout_decision,
    output logic                      frame_err
);
    localparam int SW = ((RW > IW) ? RW : IW) + 1;
    localparam logic [LOG_NUM_CLS-1:0] LAST_CHAN = LOG_NUM_CLS'(NUM_CLS - 1);

    logic [LOG_NUM_CLS-1:0] chan_idx;
    logic [NUM_CLS-1:0]     partial;
    logic [NUM_CLS-1:0]     partial_set;
    logic [NUM_CLS-1:0]     fifo_mem [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             fifo_count;
    logic [1:0]             next_count;
    logic signed [IW-1:0]   cur_icpt;
    logic signed [SW-1:0]   sum;
    logic                   dec_bit;
    logic                   is_last_chan;
    logic                   in_fire;
    logic                   push;
    logic                   pop;

    always_comb begin
        cur_icpt = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            if (chan_idx == LOG_NUM_CLS'(c)) cur_icpt = intercepts[c*IW +: IW];
        end
    end

    // Score and intercept are both widened one bit past the larger width, so the add never wraps.
    assign sum = {{(SW-RW){result[RW-1]}}, result} + {{(SW-IW){cur_icpt[IW-1]}}, cur_icpt};
    assign dec_bit = (INCLUSIVE != 0) ? !sum[SW-1] : (!sum[SW-1] && (sum != '0));

    // The top bit of partial is never set, so partial_set on the final channel is the full vector.
    always_comb begin
        partial_set = partial;
        for (int c = 0; c < NUM_CLS; c++) begin
            if (chan_idx == LOG_NUM_CLS'(c)) partial_set[c] = dec_bit;
        end
    end

    assign is_last_chan  = (chan_idx == LAST_CHAN);
    assign result_ready  = !(is_last_chan && fifo_count == 2'd2);
    assign in_fire       = result_valid && result_ready;
    assign push          = in_fire && is_last_chan;
    assign pop           = dout_valid && dout_ready;
    assign dout_fire     = pop;
    assign dout_decision = fifo_mem[rd_ptr];
    assign next_count    = fifo_count + 2'(push) - 2'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_idx    <= '0;
            partial     <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            dout_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (in_fire) begin
                if (is_last_chan || result_last) begin
                    chan_idx <= '0;
                    partial  <= '0;
                end else begin
                    chan_idx <= chan_idx + LOG_NUM_CLS'(1);
                    partial  <= partial_set;
                end
                // An early last drops the frame; a missing last still emits it.
                if (result_last != is_last_chan) frame_err <= 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= partial_set;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= next_count;
            dout_valid <= (next_count != 2'd0);
        end
    end
endmodule
